// File: rtl/downcnt_monitor.sv
// downcnt_monitor: watches a 4-bit upstream down counter and checks that it
// decrements by one (mod 16) on every qualified sample. After LOCK_CNT
// consecutive valid decrements the monitor locks. While locked it pulses on
// terminal count (0) and on wrap (0 -> F). A mismatch while locked latches a
// sticky error and counts errors, saturating at 8'hFF.
// Optional feature: define DOWNCNT_WRAP_COUNT_EN to add the wrap_count port,
// a modulo-256 count of wrap pulses.
// The reset is synchronous and active-low.
module downcnt_monitor #(
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [3:0] count_in,
  input  logic       clear,
  output logic       locked,
  output logic       tc_pulse,
  output logic       wrap_pulse,
  output logic       seq_err,
  output logic [7:0] err_count
`ifdef DOWNCNT_WRAP_COUNT_EN
  ,
  output logic [7:0] wrap_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_LOCKED,
    ST_ERROR
  } state_e;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_e     state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] match_q, match_d;
  logic       locked_q, locked_d;
  logic       tc_q, tc_d;
  logic       wrap_q, wrap_d;
  logic       seq_err_q, seq_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
`ifdef DOWNCNT_WRAP_COUNT_EN
  logic [7:0] wrap_cnt_q, wrap_cnt_d;
`endif

  logic       is_dec;
  logic [7:0] err_inc;

  // A valid decrement is prev - 1 modulo 16; the 4-bit subtraction wraps 0 to F.
  assign is_dec  = (count_in == (prev_q - 4'd1));
  assign err_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);

  // State register: every flop, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so all flops update together from
    // the values computed in the combinational process.
    if (!reset) begin
      state_q    <= ST_IDLE;
      prev_q     <= 4'hF;
      match_q    <= 4'd0;
      locked_q   <= 1'b0;
      tc_q       <= 1'b0;
      wrap_q     <= 1'b0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= 8'h00;
`ifdef DOWNCNT_WRAP_COUNT_EN
      wrap_cnt_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      locked_q   <= locked_d;
      tc_q       <= tc_d;
      wrap_q     <= wrap_d;
      seq_err_q  <= seq_err_d;
      err_cnt_q  <= err_cnt_d;
`ifdef DOWNCNT_WRAP_COUNT_EN
      wrap_cnt_q <= wrap_cnt_d;
`endif
    end
  end

  // Next-state logic: clear beats sample_en; idle cycles hold state and drop pulses.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    prev_d     = prev_q;
    match_d    = match_q;
    tc_d       = 1'b0;
    wrap_d     = 1'b0;
    seq_err_d  = seq_err_q;
    err_cnt_d  = err_cnt_q;
`ifdef DOWNCNT_WRAP_COUNT_EN
    wrap_cnt_d = wrap_cnt_q;
`endif

    if (clear) begin
      // The sample is dropped; prev keeps its last captured value.
      state_d    = ST_IDLE;
      match_d    = 4'd0;
      seq_err_d  = 1'b0;
      err_cnt_d  = 8'h00;
`ifdef DOWNCNT_WRAP_COUNT_EN
      wrap_cnt_d = 8'h00;
`endif
    end else if (sample_en) begin
      prev_d = count_in;
      unique case (state_q)
        ST_IDLE: begin
          match_d = 4'd0;
          state_d = ST_ACQ;
        end
        ST_ACQ: begin
          if (is_dec) begin
            match_d = match_q + 4'd1;
            if ((match_q + 4'd1) == LOCK_TGT) state_d = ST_LOCKED;
          end else begin
            match_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (is_dec) begin
            tc_d   = (count_in == 4'h0);
            // A valid decrement out of 0 is exactly the 0 -> F wrap.
            wrap_d = (prev_q == 4'h0);
`ifdef DOWNCNT_WRAP_COUNT_EN
            if (prev_q == 4'h0) wrap_cnt_d = wrap_cnt_q + 8'd1;
`endif
          end else begin
            state_d   = ST_ERROR;
            seq_err_d = 1'b1;
            err_cnt_d = err_inc;
          end
        end
        ST_ERROR: begin
          if (!is_dec) err_cnt_d = err_inc;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // Output logic: every output comes straight from a flop.
  always_comb begin
    locked     = locked_q;
    tc_pulse   = tc_q;
    wrap_pulse = wrap_q;
    seq_err    = seq_err_q;
    err_count  = err_cnt_q;
`ifdef DOWNCNT_WRAP_COUNT_EN
    wrap_count = wrap_cnt_q;
`endif
  end

endmodule
